// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: forwards ALU results, or runs one data-memory
// transaction per load/store with lane steering, extension and misalignment faults.
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] EXE_DATA_i,
  input  logic [XLEN-1:0] src2_data_i,
  input  logic            REG_WEN_i,
  input  logic            DM_enable_n_i,
  input  logic            DM_WEN_i,
  input  logic            WB_MUX_sel_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [2:0]      funct3_i,
  output logic            dm_req_o,
  output logic [XLEN-1:0] dm_addr_o,
  output logic            dm_we_n_o,
  output logic [3:0]      dm_bwe_n_o,
  output logic [XLEN-1:0] dm_wdata_o,
  input  logic            dm_ready_i,
  input  logic [XLEN-1:0] dm_rdata_i,
  output logic [XLEN-1:0] WB_DATA_o,
  output logic            REG_WEN_o,
  output logic [4:0]      rd_addr_o,
  output logic            stall_o,
  output logic            misalign_o
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic [3:0]      r_bwe_n;
  logic            r_we_n, r_reg_wen, r_wb_sel;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;

  logic            w_f3_ok, w_misalign, w_accept;
  logic [XLEN-1:0] w_st_wdata, w_ld_data;
  logic [3:0]      w_st_bwe_n;
  logic [7:0]      w_ld_b;
  logic [15:0]     w_ld_h;

  // Loads accept the five RV32 sizes; stores have no unsigned forms.
  always_comb begin
    w_f3_ok = DM_WEN_i ? (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                       : (funct3_i inside {3'b000, 3'b001, 3'b010});
    w_misalign = !DM_enable_n_i &&
                 (!w_f3_ok ||
                  (funct3_i[1:0] == 2'b01 && EXE_DATA_i[0]) ||
                  (funct3_i[1:0] == 2'b10 && EXE_DATA_i[1:0] != 2'b00));
    w_accept = (r_state == S_IDLE) && !DM_enable_n_i && !w_misalign;
  end

  always_comb begin
    w_st_wdata = src2_data_i;
    w_st_bwe_n = 4'b0000;
    case (funct3_i[1:0])
      2'b00: begin
        w_st_wdata = {(XLEN/8){src2_data_i[7:0]}};
        w_st_bwe_n = ~(4'b0001 << EXE_DATA_i[1:0]);
      end
      2'b01: begin
        w_st_wdata = {(XLEN/16){src2_data_i[15:0]}};
        w_st_bwe_n = ~(4'b0011 << EXE_DATA_i[1:0]);
      end
      default: ;
    endcase
    if (DM_WEN_i) w_st_bwe_n = 4'b1111;
  end

  always_comb begin
    w_ld_b = dm_rdata_i[{r_addr[1:0], 3'b000} +: 8];
    w_ld_h = dm_rdata_i[{r_addr[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_ld_data = {{(XLEN-8){w_ld_b[7]}}, w_ld_b};
      3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_ld_b};
      3'b001:  w_ld_data = {{(XLEN-16){w_ld_h[15]}}, w_ld_h};
      3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_ld_h};
      default: w_ld_data = dm_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)   w_state_nxt = S_ACCESS;
      S_ACCESS: if (dm_ready_i) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Holding registers double as the memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_bwe_n   <= 4'b1111;
      r_we_n    <= 1'b1;
      r_reg_wen <= 1'b1;
      r_wb_sel  <= 1'b0;
      r_funct3  <= 3'b000;
      r_rd      <= 5'd0;
    end else if (w_accept) begin
      r_addr    <= EXE_DATA_i;
      r_wdata   <= w_st_wdata;
      r_bwe_n   <= w_st_bwe_n;
      r_we_n    <= DM_WEN_i;
      r_reg_wen <= REG_WEN_i;
      r_wb_sel  <= WB_MUX_sel_i;
      r_funct3  <= funct3_i;
      r_rd      <= rd_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_DATA_o  <= '0;
      REG_WEN_o  <= 1'b1;
      rd_addr_o  <= 5'd0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      if (r_state == S_IDLE) begin
        if (DM_enable_n_i) begin
          WB_DATA_o <= EXE_DATA_i;
          REG_WEN_o <= REG_WEN_i;
          rd_addr_o <= rd_addr_i;
        end else begin
          misalign_o <= w_misalign;
          REG_WEN_o  <= 1'b1;
        end
      end else if (dm_ready_i && r_we_n) begin
        WB_DATA_o <= r_wb_sel ? w_ld_data : r_addr;
        REG_WEN_o <= r_reg_wen;
        rd_addr_o <= r_rd;
      end else begin
        REG_WEN_o <= 1'b1;
      end
    end
  end

  assign dm_req_o   = (r_state == S_ACCESS);
  assign dm_addr_o  = {r_addr[XLEN-1:2], 2'b00};
  assign dm_we_n_o  = r_we_n;
  assign dm_bwe_n_o = r_bwe_n;
  assign dm_wdata_o = r_wdata;
  assign stall_o    = (r_state == S_ACCESS) && !dm_ready_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench: directed scenarios plus randomized ALU/load/store traffic
// checked against an arithmetic reference model and a bench-driven memory.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] EXE_DATA_i = '0, src2_data_i = '0, dm_rdata_i = '0;
  logic        REG_WEN_i = 1'b1, DM_enable_n_i = 1'b1, DM_WEN_i = 1'b1, WB_MUX_sel_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        dm_ready_i = 1'b0;
  logic        dm_req_o, dm_we_n_o, REG_WEN_o, stall_o, misalign_o;
  logic [31:0] dm_addr_o, dm_wdata_o, WB_DATA_o;
  logic [3:0]  dm_bwe_n_o;
  logic [4:0]  rd_addr_o;
  int total = 0, bad = 0;

  mem_access_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .EXE_DATA_i(EXE_DATA_i), .src2_data_i(src2_data_i), .REG_WEN_i(REG_WEN_i),
    .DM_enable_n_i(DM_enable_n_i), .DM_WEN_i(DM_WEN_i), .WB_MUX_sel_i(WB_MUX_sel_i),
    .rd_addr_i(rd_addr_i), .funct3_i(funct3_i),
    .dm_req_o(dm_req_o), .dm_addr_o(dm_addr_o), .dm_we_n_o(dm_we_n_o),
    .dm_bwe_n_o(dm_bwe_n_o), .dm_wdata_o(dm_wdata_o),
    .dm_ready_i(dm_ready_i), .dm_rdata_i(dm_rdata_i),
    .WB_DATA_o(WB_DATA_o), .REG_WEN_o(REG_WEN_o), .rd_addr_o(rd_addr_o),
    .stall_o(stall_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit ref_misaligned(input bit is_load, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    bit legal;
    legal = is_load ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    if (!legal) return 1'b1;
    nbytes = 1 << f3[1:0];
    return (a % nbytes) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 0 && v >= 128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (f3 == 1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_bwe(input bit is_load, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    int lo, nb;
    m = 4'hF;
    if (is_load) return m;
    lo = a % 4;
    nb = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) if (i >= lo && i < lo + nb) m[i] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return (d & 32'hFF) * 32'h0101_0101;
      2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_alu(input logic [31:0] d, input logic wen, input logic [4:0] rd);
    EXE_DATA_i = d; REG_WEN_i = wen; rd_addr_i = rd; DM_enable_n_i = 1'b1;
    DM_WEN_i = 1'b1; WB_MUX_sel_i = 1'b0; funct3_i = 3'd0; src2_data_i = $urandom;
  endtask

  task automatic set_mem(input bit is_load, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] s2, input logic wen, input logic [4:0] rd);
    EXE_DATA_i = a; src2_data_i = s2; funct3_i = f3; DM_enable_n_i = 1'b0;
    DM_WEN_i = is_load; WB_MUX_sel_i = is_load; REG_WEN_i = wen; rd_addr_i = rd;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    total++; if (dm_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", dm_req_o); end
    total++; if (dm_we_n_o !== 1'b1) begin bad++; $display("FAIL rst_we_n got=%b exp=1", dm_we_n_o); end
    total++; if (dm_bwe_n_o !== 4'hF) begin bad++; $display("FAIL rst_bwe got=%h exp=f", dm_bwe_n_o); end
    total++; if ({dm_addr_o, dm_wdata_o, WB_DATA_o} !== '0) begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", dm_addr_o, dm_wdata_o, WB_DATA_o); end
    total++; if ({REG_WEN_o, rd_addr_o, stall_o, misalign_o} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin bad++; $display("FAIL rst_wb got=%b/%0d/%b/%b exp=1/0/0/0", REG_WEN_o, rd_addr_o, stall_o, misalign_o); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_alu;
    @(negedge clk) set_alu(32'h1234_5678, 1'b0, 5'd5);
    tick;
    total++; if ({WB_DATA_o, REG_WEN_o, rd_addr_o, stall_o} !== {32'h1234_5678, 1'b0, 5'd5, 1'b0}) begin bad++; $display("FAIL alu got=%h/%b/%0d/%b exp=12345678/0/5/0", WB_DATA_o, REG_WEN_o, rd_addr_o, stall_o); end
  endtask

  task automatic test_lb;
    @(negedge clk) set_mem(1'b1, 3'd0, 32'h103, 32'h0, 1'b0, 5'd7);
    tick;
    EXE_DATA_i = 32'hDEAD_0000; DM_enable_n_i = 1'b1; dm_ready_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      total++; if ({dm_req_o, dm_addr_o, stall_o, dm_bwe_n_o} !== {1'b1, 32'h100, 1'b1, 4'hF}) begin bad++; $display("FAIL lb_wait%0d got=%b/%h/%b/%h exp=1/00000100/1/f", w, dm_req_o, dm_addr_o, stall_o, dm_bwe_n_o); end
      tick;
    end
    dm_ready_i = 1'b1; dm_rdata_i = 32'h80FF_0000;
    tick;
    dm_ready_i = 1'b0;
    total++; if ({WB_DATA_o, REG_WEN_o, rd_addr_o, dm_req_o} !== {32'hFFFF_FF80, 1'b0, 5'd7, 1'b0}) begin bad++; $display("FAIL lb_wb got=%h/%b/%0d/%b exp=ffffff80/0/7/0", WB_DATA_o, REG_WEN_o, rd_addr_o, dm_req_o); end
  endtask

  task automatic test_sh;
    @(negedge clk) set_mem(1'b0, 3'd1, 32'h202, 32'h1234_BEEF, 1'b0, 5'd3);
    tick;
    total++; if ({dm_req_o, dm_we_n_o, dm_bwe_n_o, dm_wdata_o, dm_addr_o} !== {1'b1, 1'b0, 4'b0011, 32'hBEEF_BEEF, 32'h200}) begin bad++; $display("FAIL sh_req got=%b/%b/%b/%h/%h exp=1/0/0011/beefbeef/00000200", dm_req_o, dm_we_n_o, dm_bwe_n_o, dm_wdata_o, dm_addr_o); end
    dm_ready_i = 1'b1; DM_enable_n_i = 1'b1;
    tick;
    dm_ready_i = 1'b0;
    total++; if ({REG_WEN_o, dm_req_o} !== 2'b10) begin bad++; $display("FAIL sh_done got=%b/%b exp=1/0", REG_WEN_o, dm_req_o); end
  endtask

  task automatic test_misalign;
    @(negedge clk) set_mem(1'b1, 3'd2, 32'h301, 32'h0, 1'b0, 5'd9);
    tick;
    total++; if ({dm_req_o, misalign_o, REG_WEN_o} !== 3'b011) begin bad++; $display("FAIL mis_pulse got=%b/%b/%b exp=0/1/1", dm_req_o, misalign_o, REG_WEN_o); end
    set_alu(32'h0, 1'b1, 5'd0);
    tick;
    total++; if ({dm_req_o, misalign_o} !== 2'b00) begin bad++; $display("FAIL mis_clear got=%b/%b exp=0/0", dm_req_o, misalign_o); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk) set_mem(1'b1, 3'd2, 32'h500, 32'h0, 1'b0, 5'd4);
    tick;
    dm_ready_i = 1'b0;
    total++; if ({dm_req_o, stall_o} !== 2'b11) begin bad++; $display("FAIL rmid_pre got=%b/%b exp=1/1", dm_req_o, stall_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({dm_req_o, stall_o, REG_WEN_o} !== 3'b001) begin bad++; $display("FAIL rmid_async got=%b/%b/%b exp=0/0/1", dm_req_o, stall_o, REG_WEN_o); end
    @(negedge clk) rst_n = 1'b1;
    set_alu(32'hCAFE_F00D, 1'b0, 5'd12);
    tick;
    total++; if ({WB_DATA_o, REG_WEN_o, rd_addr_o, dm_req_o} !== {32'hCAFE_F00D, 1'b0, 5'd12, 1'b0}) begin bad++; $display("FAIL rmid_after got=%h/%b/%0d/%b exp=cafef00d/0/12/0", WB_DATA_o, REG_WEN_o, rd_addr_o, dm_req_o); end
  endtask

  task automatic test_lhu_zero_wait;
    @(negedge clk) set_mem(1'b1, 3'd5, 32'h402, 32'h0, 1'b0, 5'd21);
    dm_ready_i = 1'b1; dm_rdata_i = 32'h9ABC_0000;
    tick;
    DM_enable_n_i = 1'b1;
    total++; if ({dm_req_o, stall_o, REG_WEN_o} !== 3'b101) begin bad++; $display("FAIL lhu_acc got=%b/%b/%b exp=1/0/1", dm_req_o, stall_o, REG_WEN_o); end
    tick;
    dm_ready_i = 1'b0;
    total++; if ({WB_DATA_o, REG_WEN_o, rd_addr_o} !== {32'h0000_9ABC, 1'b0, 5'd21}) begin bad++; $display("FAIL lhu_wb got=%h/%b/%0d exp=00009abc/0/21", WB_DATA_o, REG_WEN_o, rd_addr_o); end
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a, s2, rdata, exp_wb;
    logic [4:0]  rd;
    logic        wen;
    bit          is_load, mis;
    int          kind, waits;
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom; s2 = $urandom; rd = 5'($urandom); wen = 1'($urandom);
      if (kind == 0) begin
        set_alu(a, wen, rd);
        tick;
        total++; if ({WB_DATA_o, REG_WEN_o, rd_addr_o, stall_o, dm_req_o, misalign_o} !== {a, wen, rd, 3'b000}) begin bad++; $display("FAIL rnd_alu n=%0d got=%h/%b/%0d/%b%b%b exp=%h/%b/%0d/000", n, WB_DATA_o, REG_WEN_o, rd_addr_o, stall_o, dm_req_o, misalign_o, a, wen, rd); end
        continue;
      end
      is_load = (kind == 1);
      f3 = 3'($urandom_range(0, 7));
      if (!is_load && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      mis = ref_misaligned(is_load, f3, a);
      set_mem(is_load, f3, a, s2, wen, rd);
      tick;
      if (mis) begin
        total++; if ({dm_req_o, misalign_o, REG_WEN_o} !== 3'b011) begin bad++; $display("FAIL rnd_mis n=%0d f3=%0d a=%h got=%b/%b/%b exp=0/1/1", n, f3, a, dm_req_o, misalign_o, REG_WEN_o); end
        continue;
      end
      total++; if ({dm_req_o, misalign_o, dm_addr_o, dm_we_n_o, dm_bwe_n_o} !== {2'b10, a & ~32'h3, is_load, ref_bwe(is_load, f3, a)}) begin bad++; $display("FAIL rnd_req n=%0d got=%b%b/%h/%b/%h exp=10/%h/%b/%h", n, dm_req_o, misalign_o, dm_addr_o, dm_we_n_o, dm_bwe_n_o, a & ~32'h3, is_load, ref_bwe(is_load, f3, a)); end
      if (!is_load) begin
        total++; if (dm_wdata_o !== ref_wdata(f3, s2)) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, dm_wdata_o, ref_wdata(f3, s2)); end
      end
      // upstream garbage while stalled must have no effect
      EXE_DATA_i = $urandom; src2_data_i = $urandom; DM_enable_n_i = 1'($urandom);
      funct3_i = 3'($urandom); rd_addr_i = 5'($urandom); REG_WEN_i = 1'($urandom);
      waits = $urandom_range(0, 3);
      dm_ready_i = 1'b0;
      for (int w = 0; w < waits; w++) begin
        total++; if ({stall_o, dm_req_o, dm_addr_o} !== {2'b11, a & ~32'h3}) begin bad++; $display("FAIL rnd_stall n=%0d got=%b%b/%h exp=11/%h", n, stall_o, dm_req_o, dm_addr_o, a & ~32'h3); end
        tick;
        total++; if (REG_WEN_o !== 1'b1) begin bad++; $display("FAIL rnd_bubble n=%0d got=%b exp=1", n, REG_WEN_o); end
      end
      rdata = $urandom;
      dm_ready_i = 1'b1; dm_rdata_i = rdata;
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rnd_ready_stall n=%0d got=%b exp=0", n, stall_o); end
      tick;
      dm_ready_i = 1'b0;
      if (is_load) begin
        exp_wb = ref_load(rdata, f3, a);
        total++; if ({WB_DATA_o, REG_WEN_o, rd_addr_o, dm_req_o} !== {exp_wb, wen, rd, 1'b0}) begin bad++; $display("FAIL rnd_load n=%0d f3=%0d a=%h rdata=%h got=%h/%b/%0d/%b exp=%h/%b/%0d/0", n, f3, a, rdata, WB_DATA_o, REG_WEN_o, rd_addr_o, dm_req_o, exp_wb, wen, rd); end
      end else begin
        total++; if ({REG_WEN_o, dm_req_o} !== 2'b10) begin bad++; $display("FAIL rnd_store n=%0d got=%b/%b exp=1/0", n, REG_WEN_o, dm_req_o); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_lb;
    test_sh;
    test_misalign;
    test_reset_mid;
    test_lhu_zero_wait;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have these inputs from the EX/MEM register:
- EXE_DATA_i, XLEN: ALU result or memory byte address.
- src2_data_i, XLEN: store data.
- REG_WEN_i, 1: register write enable, active-low.
- DM_enable_n_i, 1: memory access request, active-low.
- DM_WEN_i, 1: memory write, active-low (0 = store, 1 = load).
- WB_MUX_sel_i, 1: 1 = memory data to writeback, 0 = EXE_DATA_i.
- rd_addr_i, 5: destination register.
- funct3_i, 3: access size and sign.
REQ-005 The block SHALL have these data memory outputs:
- dm_req_o, 1: request.
- dm_addr_o, XLEN: word address with bits [1:0] = 0.
- dm_we_n_o, 1: write, active-low.
- dm_bwe_n_o, 4: byte write enables, active-low.
- dm_wdata_o, XLEN: lane-aligned store data.
REQ-006 The block SHALL have these data memory inputs:
- dm_ready_i, 1: access complete.
- dm_rdata_i, XLEN: word read data, valid when dm_ready_i = 1.
REQ-007 The block SHALL have these outputs to writeback and upstream:
- WB_DATA_o, XLEN: writeback data.
- REG_WEN_o, 1: active-low.
- rd_addr_o, 5: destination register.
- stall_o, 1: upstream holds its inputs.
- misalign_o, 1: one-cycle fault pulse.

Function
REQ-008 The block SHALL implement a two-state FSM:
- IDLE -> ACCESS when DM_enable_n_i = 0 and the address is aligned.
- ACCESS -> IDLE on the edge where dm_ready_i = 1.
REQ-009 In IDLE, the block SHALL capture the address, store data, funct3, control and rd into internal holding registers on the IDLE->ACCESS edge.
REQ-010 The block SHALL drive dm_req_o = 1 throughout ACCESS, and 0 in IDLE.
REQ-011 The block SHALL hold dm_addr_o, dm_we_n_o, dm_bwe_n_o and dm_wdata_o stable from the holding registers throughout ACCESS.
REQ-012 The block SHALL drive stall_o = 1 combinationally while in ACCESS and dm_ready_i = 0, and 0 otherwise.
REQ-013 For a non-memory op in IDLE (DM_enable_n_i = 1), the block SHALL register WB_DATA_o <= EXE_DATA_i, REG_WEN_o <= REG_WEN_i and rd_addr_o <= rd_addr_i, giving 1-cycle latency.
REQ-014 While in ACCESS with dm_ready_i = 0, the block SHALL register a bubble: REG_WEN_o <= 1, with WB_DATA_o and rd_addr_o held.
REQ-015 On the ACCESS completion edge for a load, the block SHALL register:
- WB_DATA_o <= the extracted load value.
- REG_WEN_o <= the held REG_WEN.
- rd_addr_o <= the held rd.
REQ-016 On the ACCESS completion edge for a store, the block SHALL register REG_WEN_o <= 1.
REQ-017 Load extraction SHALL select the lane using addr[1:0] and extend it to XLEN as follows:
- funct3 000 (LB): sign-extend byte.
- funct3 100 (LBU): zero-extend byte.
- funct3 001 (LH): sign-extend halfword, using addr[1] for the lane.
- funct3 101 (LHU): zero-extend halfword, using addr[1] for the lane.
- funct3 010 (LW): full word.
REQ-018 Stores SHALL set byte enables and data as follows:
- funct3 000 (SB): dm_bwe_n_o = ~(4'b0001 << addr[1:0]), byte replicated on all lanes.
- funct3 001 (SH): dm_bwe_n_o = ~(4'b0011 << addr[1:0]), halfword replicated.
- funct3 010 (SW): dm_bwe_n_o = 4'b0000.
REQ-019 For loads, the block SHALL drive dm_bwe_n_o = 4'b1111.
REQ-020 The following SHALL be treated as misaligned:
- Halfword access with addr[0] = 1.
- Word access with addr[1:0] != 0.
- Any other funct3 value on a memory op.
REQ-021 On a misaligned access, the block SHALL:
- issue no request;
- stay in IDLE;
- register misalign_o <= 1 for exactly one cycle;
- register REG_WEN_o <= 1.
REQ-022 In ACCESS, the block SHALL ignore all upstream inputs, since upstream holds them while stall_o = 1.
REQ-023 If dm_ready_i = 1 on the first ACCESS cycle, the access SHALL complete with 2-cycle latency from acceptance to WB_DATA_o.
REQ-024 The block SHALL ignore dm_ready_i while in IDLE.

Reset
REQ-025 While rst_n = 0, the block SHALL immediately, without waiting for a clock edge, set the state to IDLE and drive:
- dm_req_o = 0, dm_we_n_o = 1, dm_bwe_n_o = 4'b1111, dm_addr_o = 0, dm_wdata_o = 0.
- WB_DATA_o = 0, REG_WEN_o = 1, rd_addr_o = 0.
- stall_o = 0, misalign_o = 0.
REQ-026 A reset asserted during ACCESS SHALL abandon the access without any register write, and dm_req_o SHALL fall asynchronously.

Verification
REQ-027 Test ALU pass-through: EXE_DATA_i = 32'h1234_5678, REG_WEN_i = 0, rd = 5, DM_enable_n_i = 1 -> next edge WB_DATA_o = 32'h1234_5678, REG_WEN_o = 0, rd_addr_o = 5, stall_o = 0.
REQ-028 Test LB with sign extension: addr 32'h103, funct3 000, dm_ready_i = 1 after 2 wait cycles, dm_rdata_i = 32'h80FF_0000 -> expect:
- dm_addr_o = 32'h100 and stall_o = 1 for 2 cycles;
- WB_DATA_o = 32'hFFFF_FF80 one edge after ready.
REQ-029 Test SH: addr 32'h202, src2 = 32'hXXXX_BEEF -> dm_bwe_n_o = 4'b0011, dm_wdata_o = 32'hBEEF_BEEF, dm_we_n_o = 0, REG_WEN_o = 1 after completion.
REQ-030 Test misaligned LW: addr 32'h301, funct3 010 -> dm_req_o never asserts, misalign_o = 1 for exactly one cycle, REG_WEN_o = 1.
REQ-031 Test reset mid-access: assert rst_n = 0 during ACCESS between clock edges -> dm_req_o = 0 and stall_o = 0 immediately; after release, the block is in IDLE and the next ALU op passes normally.
REQ-032 Test zero-wait LHU: addr 32'h402, dm_ready_i already 1, dm_rdata_i = 32'h9ABC_0000 -> WB_DATA_o = 32'h0000_9ABC two edges after acceptance.
